// File: rtl/twenty48_pkg.sv
// twenty48_pkg: shared types and constants for the board-to-text serial path.
//   char_t            : one ASCII character from the formatter
//   tx_state_t        : UART transmitter state encoding
//   ASCII_NUL         : end-of-string marker, never transmitted
//   DataBits          : data bits per frame
//   FrameBitsNoParity : bit times per 8N1 frame (start + 8 data + stop)
//   FrameBitsParity   : bit times per 8E1 frame (start + 8 data + parity + stop)
package twenty48_pkg;

  typedef logic [7:0] char_t;

  localparam char_t ASCII_NUL = 8'h00;

  localparam int unsigned DataBits          = 8;
  localparam int unsigned FrameBitsNoParity = 10;
  localparam int unsigned FrameBitsParity   = 11;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StData,
    StParity,
    StStop,
    StSettle
  } tx_state_t;

endpackage

// File: rtl/board_uart_tx_if.sv
// board_uart_tx_if: character handshake between the board-to-text formatter and the UART.
//   processing : formatter busy rebuilding its string, char_in not valid
//   char_in    : current character offered by the formatter
//   print_nxt  : one-cycle pulse consuming char_in and advancing the formatter
// Modports: master = formatter side, slave = UART transmitter side.
interface board_uart_tx_if;
  import twenty48_pkg::*;

  logic  processing;
  char_t char_in;
  logic  print_nxt;

  modport master (
    output processing,
    output char_in,
    input  print_nxt
  );

  modport slave (
    input  processing,
    input  char_in,
    output print_nxt
  );

endinterface

// File: rtl/board_uart_tx_baud_tick.sv
// baud_tick: bit-period timer for the UART transmitter.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear, restarts the bit period
//   tick  : high during the last cycle of each DIV-cycle bit period
// The counter runs 0..DIV-1 and wraps; no fractional-rate correction.
module baud_tick #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || (cnt_q == CntMax)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Decoded from the registered count, so it is clean for the FSM to sample.
  assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/board_uart_tx.sv
// board_uart_tx: serial output stage behind the board-to-text formatter.
// Pulls characters one at a time over the fmt handshake and sends each as an
// asynchronous UART frame, LSB first. A NUL character halts fetching without
// being consumed until the formatter presents a non-NUL character again.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (forces tx high at once)
//   fmt   : board_uart_tx_if.slave (processing, char_in in; print_nxt out)
//   tx    : UART line, idle high, registered
//   busy  : high whenever the transmitter is not idle, registered
// Parameters: CLK_HZ, BAUD; bit period DIV = CLK_HZ / BAUD (truncated), DIV >= 2.
// Build option: define BOARD_UART_TX_PARITY_EN for 8E1 frames (even parity
// bit between data and stop); otherwise frames are 8N1.
module board_uart_tx
  import twenty48_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 115_200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  board_uart_tx_if.slave        fmt,
  output logic                  tx,
  output logic                  busy
);

  localparam int unsigned DIV = CLK_HZ / BAUD;

  tx_state_t state_q;
  char_t     shreg_q;
  logic [2:0] idx_q;
  logic      tx_q;
  logic      busy_q;
  logic      print_nxt_q;
`ifdef BOARD_UART_TX_PARITY_EN
  logic      parity_q;
`endif

  logic tick;
  logic load;

  assign load = (state_q == StLoad);

  // Bit timing restarts in LOAD so the start bit is a full DIV cycles long.
  baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (load),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      idx_q       <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      print_nxt_q <= 1'b0;
`ifdef BOARD_UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      print_nxt_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // The character is latched here, so later char_in changes cannot
          // corrupt the frame in flight.
          if (!fmt.processing && (fmt.char_in != ASCII_NUL)) begin
            shreg_q     <= fmt.char_in;
`ifdef BOARD_UART_TX_PARITY_EN
            parity_q    <= ^fmt.char_in;
`endif
            print_nxt_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= StLoad;
          end
        end
        StLoad: begin
          tx_q    <= 1'b0;
          state_q <= StStart;
        end
        StStart: begin
          if (tick) begin
            tx_q    <= shreg_q[0];
            idx_q   <= '0;
            state_q <= StData;
          end
        end
        StData: begin
          if (tick) begin
            shreg_q <= shreg_q >> 1;
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'(DataBits - 1)) begin
`ifdef BOARD_UART_TX_PARITY_EN
              tx_q    <= parity_q;
              state_q <= StParity;
`else
              tx_q    <= 1'b1;
              state_q <= StStop;
`endif
            end else begin
              tx_q <= shreg_q[1];
            end
          end
        end
        StParity: begin
          if (tick) begin
            tx_q    <= 1'b1;
            state_q <= StStop;
          end
        end
        StStop: begin
          if (tick) begin
            state_q <= StSettle;
          end
        end
        StSettle: begin
          // One quiet cycle lets the formatter present its next character.
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign tx            = tx_q;
  assign busy          = busy_q;
  assign fmt.print_nxt = print_nxt_q;

endmodule

// File: doc/board_uart_tx.md
# board_uart_tx

Serial output stage directly downstream of the board-to-text formatter. It pulls ASCII characters one at a time from the formatter's `char_out`, acknowledging each with a one-cycle `print_nxt` pulse. Each character goes out as an asynchronous 8N1 UART frame on `tx` to the host terminal. A NUL character (0x00) marks end of string and halts fetching until the formatter re-arms.

## Interface
- `CLK_HZ`, default 100_000_000: system clock frequency in Hz.
- `BAUD`, default 115_200: line rate. `DIV = CLK_HZ / BAUD` (truncated) clock cycles per bit; `DIV >= 2` is required.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `processing`  in  1  formatter busy rebuilding its string; when high, `char_in` is not valid.
- `char_in`  in  8  current character from formatter (`char_out`).
- `print_nxt`  out  1  one-cycle pulse that consumes `char_in` and advances the formatter.
- `tx`  out  1  UART line, idle high.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, LOAD, START, DATA, [PARITY], STOP, SETTLE.
- IDLE: if `processing == 0` and `char_in != 8'h00`, latch `char_in` into `shreg` and go to LOAD. Otherwise hold.
- LOAD, 1 cycle:
  - `print_nxt = 1`; reset baud counter; go to START.
- START: `tx = 0` for DIV cycles, then DATA with bit index 0.
- DATA: `tx = shreg[0]`, LSB first. After DIV cycles, shift right and increment index. After index 7 completes, go to PARITY if enabled, else STOP.
- STOP: `tx = 1` for DIV cycles, then SETTLE.
- SETTLE, 1 cycle: `tx = 1`. Gives the formatter one cycle after `print_nxt` to present the next character. Then IDLE.
- End of string:
  - `char_in == 0x00` in IDLE: no pulse and no frame. Stay in IDLE until `char_in` becomes non-zero with `processing` low.
  - The NUL is never consumed.
- `processing` rising mid-frame: the current frame completes normally. IDLE then waits.
- `char_in` changing mid-frame has no effect, because the character is latched at IDLE→LOAD.

## Timing
- Reset values: `tx = 1`, `print_nxt = 0`, `busy = 0`, state IDLE, counters 0. Assertion mid-frame forces `tx` high immediately (asynchronous).
- Latency from the eligible IDLE cycle to the `tx` falling edge: 2 cycles (latch edge, then the LOAD cycle). `print_nxt` is high during the LOAD cycle.
- Frame length on `tx`: 10·DIV cycles (11·DIV with parity).
- Character-to-character period: 2 + 10·DIV + 1 cycles.
- Baud counter is `$clog2(DIV)` bits wide. It counts 0..DIV−1 and wraps at a bit boundary. No fractional-rate correction.
- Outputs are registered. `tx` is glitch-free.

## Configuration
- `BOARD_UART_TX_PARITY_EN`
  - Defined: a PARITY state between DATA and STOP sends even parity (`^latched_char`) for DIV cycles. The frame becomes 8E1, 11·DIV cycles.
  - Undefined: no PARITY state; frame is 8N1.

## Structure
- Shared package `twenty48_pkg` holds:
  - the state enum `tx_state_t`;
  - `ASCII_NUL = 8'h00`;
  - the frame-length constants.
- One sub-module, `baud_tick`. It is parameterised by DIV, has a synchronous clear driven by LOAD, and outputs a one-cycle `tick` at each bit end.

## Test plan
All tests use CLK_HZ=1_000_000, BAUD=100_000, so DIV=10.
- After reset, hold `processing=1`, `char_in=0x41` -> `tx` stays 1 and `print_nxt` never pulses.
- `processing=0`, `char_in=0x41` -> a single `print_nxt` pulse. Then `tx` carries 0,1,0,0,0,0,0,1,0,1, each bit 10 cycles. `busy` drops 1 cycle after the stop bit.
- Model formatter streams "2\n" then 0x00 -> exactly 2 frames (0x32, 0x0A) and 2 pulses. The line then idles with `busy=0` indefinitely.
- Assert `rst_n=0` during bit 3 of 0x55 -> `tx=1` and `busy=0` in the same cycle. After release, no frame starts until the IDLE conditions are met.
- Change `char_in` from 0x41 to 0x42 mid-frame -> the transmitted byte is still 0x41.
- With `BOARD_UART_TX_PARITY_EN` defined, send 0x41 -> a parity bit of 0 follows the data bits. Frame is 110 cycles.
